pipe_lane_counter_bank: RTL and testbench

Multi-lane, parametrised PIPE symbol counter bank for the RX second half. It holds one independent counter per lane. Each counter advances by a shared per-cycle step of 1, 2 or 4 symbols for 8/16/32-bit PIPE datapaths and has a programmable terminal count with wrap or saturate behaviour. Each lane reports terminal-count events, and the bank reports a lane-alignment flag to the deskew and ordered-set tracking logic.

---
 rtl/pipe_lane_counter_bank.sv | 124 ++++++++++++
 tb/tb_pipe_lane_counter_bank.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_lane_counter_bank.sv
// Multi-lane PIPE symbol counter bank with shared step, programmable terminal count and wrap/saturate.
// Optional sticky per-lane overflow flags are enabled by defining PIPE_CNT_STICKY_OVF_EN.
module pipe_lane_counter_bank #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned CNT_WIDTH  = 4,
    parameter int unsigned MAX_CNT    = 2**CNT_WIDTH - 1,
    parameter int unsigned STEP_WIDTH = 3,
    parameter int unsigned SAT_MODE   = 0
) (
    input  logic                       CLK,
    input  logic                       Hard_RST,
    input  logic [LANES-1:0]           i_CNT_rst,
    input  logic [LANES-1:0]           i_CNT_set,
    input  logic [LANES-1:0]           i_CNT_EN,
    input  logic [STEP_WIDTH-1:0]      i_STEP,
    input  logic [CNT_WIDTH-1:0]       i_SET_VAL,
    output logic [LANES*CNT_WIDTH-1:0] o_CNT,
    output logic [LANES-1:0]           o_TC,
    output logic                       o_ALL_EQ,
    output logic [LANES-1:0]           o_OVF
);

    localparam int unsigned SUM_W = CNT_WIDTH + 1;
    localparam logic [SUM_W-1:0]     MAX_S = SUM_W'(MAX_CNT);
    localparam logic [SUM_W-1:0]     MOD_S = SUM_W'(MAX_CNT + 1);
    localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_CNT);

    logic [CNT_WIDTH-1:0] cnt_q [LANES];
    logic [CNT_WIDTH-1:0] cnt_d [LANES];
    logic [SUM_W-1:0]     sum   [LANES];
    logic [SUM_W-1:0]     step_ext;
    logic [LANES-1:0]     tc_q, tc_d;
    logic                 all_eq_q, all_eq_d;

    // Sum kept one bit wider than the counter so crossing MAX_CNT is never lost.
    always_comb begin
        step_ext = SUM_W'(i_STEP);
        for (int unsigned k = 0; k < LANES; k++) begin
            sum[k] = {1'b0, cnt_q[k]} + step_ext;
        end
    end

    always_comb begin
        all_eq_d = 1'b1;
        for (int unsigned k = 0; k < LANES; k++) begin
            cnt_d[k] = cnt_q[k];
            tc_d[k]  = 1'b0;
            if (i_CNT_rst[k]) begin
                cnt_d[k] = '0;
            end else if (i_CNT_set[k]) begin
                cnt_d[k] = (i_SET_VAL > MAX_C) ? MAX_C : i_SET_VAL;
            end else if (i_CNT_EN[k]) begin
                if (sum[k] <= MAX_S) begin
                    cnt_d[k] = sum[k][CNT_WIDTH-1:0];
                end else if (SAT_MODE != 0) begin
                    cnt_d[k] = MAX_C;
                end else begin
                    cnt_d[k] = CNT_WIDTH'(sum[k] - MOD_S);
                end
                tc_d[k] = (step_ext != '0) && (sum[k] >= MAX_S);
            end
        end
        // Equality is taken on next-state counts so the flag lines up with o_CNT.
        for (int unsigned k = 1; k < LANES; k++) begin
            if (cnt_d[k] != cnt_d[0]) begin
                all_eq_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Hard_RST) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                cnt_q[k] <= '0;
            end
            tc_q     <= '0;
            all_eq_q <= 1'b1;
        end else begin
            for (int unsigned k = 0; k < LANES; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            tc_q     <= tc_d;
            all_eq_q <= all_eq_d;
        end
    end

    always_comb begin
        o_CNT = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            o_CNT[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
        end
    end

    assign o_TC     = tc_q;
    assign o_ALL_EQ = all_eq_q;

`ifdef PIPE_CNT_STICKY_OVF_EN
    logic [LANES-1:0] ovf_q, ovf_d;

    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            ovf_d[k] = ovf_q[k];
            if (i_CNT_rst[k]) begin
                ovf_d[k] = 1'b0;
            end else if (!i_CNT_set[k] && i_CNT_EN[k] && (sum[k] > MAX_S)) begin
                ovf_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Hard_RST) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_OVF = ovf_q;
`else
    assign o_OVF = '0;
`endif

endmodule

// File: tb/tb_pipe_lane_counter_bank.sv
// Directed self-checking bench for pipe_lane_counter_bank: default wrap bank, saturating MAX=10 bank
// and wrapping MAX=9 bank; overflow expectations follow PIPE_CNT_STICKY_OVF_EN.
module tb_pipe_lane_counter_bank;

`ifdef PIPE_CNT_STICKY_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic hrst;
    always #5 clk = ~clk;

    logic [3:0]  r0, s0, e0, sv0, tc0, ovf0;
    logic [2:0]  st0;
    logic [15:0] cnt0;
    logic        eq0;

    logic [1:0] r1, s1, e1, tc1, ovf1;
    logic [2:0] st1;
    logic [3:0] sv1;
    logic [7:0] cnt1;
    logic       eq1;

    logic [1:0] r2, s2, e2, tc2, ovf2;
    logic [2:0] st2;
    logic [3:0] sv2;
    logic [7:0] cnt2;
    logic       eq2;

    int total = 0;
    int bad   = 0;

    pipe_lane_counter_bank u0 (
        .CLK(clk), .Hard_RST(hrst), .i_CNT_rst(r0), .i_CNT_set(s0), .i_CNT_EN(e0),
        .i_STEP(st0), .i_SET_VAL(sv0), .o_CNT(cnt0), .o_TC(tc0), .o_ALL_EQ(eq0), .o_OVF(ovf0)
    );

    pipe_lane_counter_bank #(
        .LANES(2), .CNT_WIDTH(4), .MAX_CNT(10), .STEP_WIDTH(3), .SAT_MODE(1)
    ) u1 (
        .CLK(clk), .Hard_RST(hrst), .i_CNT_rst(r1), .i_CNT_set(s1), .i_CNT_EN(e1),
        .i_STEP(st1), .i_SET_VAL(sv1), .o_CNT(cnt1), .o_TC(tc1), .o_ALL_EQ(eq1), .o_OVF(ovf1)
    );

    pipe_lane_counter_bank #(
        .LANES(2), .CNT_WIDTH(4), .MAX_CNT(9), .STEP_WIDTH(3), .SAT_MODE(0)
    ) u2 (
        .CLK(clk), .Hard_RST(hrst), .i_CNT_rst(r2), .i_CNT_set(s2), .i_CNT_EN(e2),
        .i_STEP(st2), .i_SET_VAL(sv2), .o_CNT(cnt2), .o_TC(tc2), .o_ALL_EQ(eq2), .o_OVF(ovf2)
    );

    // Step must never exceed MAX_CNT+1 for any enabled lane.
    always @(posedge clk) begin
        if (e0 != '0) assert (st0 <= 3'd7) else $error("illegal step u0 %0d", st0);
        if (e1 != '0) assert (st1 <= 3'd7) else $error("illegal step u1 %0d", st1);
        if (e2 != '0) assert (st2 <= 3'd7) else $error("illegal step u2 %0d", st2);
    end

    function automatic logic [3:0] ov(input logic [3:0] v);
        return OVF_ON ? v : 4'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        hrst = 1'b1;
        r0 = '0; s0 = '0; e0 = '0; st0 = '0; sv0 = '0;
        r1 = '0; s1 = '0; e1 = '0; st1 = '0; sv1 = '0;
        r2 = '0; s2 = '0; e2 = '0; st2 = '0; sv2 = '0;

        // Reset state
        tick();
        check("rst_cnt", 32'(cnt0), 32'h0);
        check("rst_tc",  32'(tc0),  32'h0);
        check("rst_eq",  32'(eq0),  32'h1);
        check("rst_ovf", 32'(ovf0), 32'h0);

        // Step 1 on all lanes for 16 cycles
        hrst = 1'b0; e0 = 4'hF; st0 = 3'd1;
        for (int i = 1; i <= 16; i++) begin
            logic [3:0] n;
            n = 4'(i % 16);
            tick();
            check("step1_cnt", 32'(cnt0), 32'({n, n, n, n}));
            check("step1_tc",  32'(tc0),  (i >= 15) ? 32'hF : 32'h0);
            check("step1_eq",  32'(eq0),  32'h1);
        end
        check("step1_ovf", 32'(ovf0), 32'(ov(4'hF)));

        // Per-lane clear, then lane 0 loaded to 13 and advanced by 4
        e0 = 4'h0; r0 = 4'hF;
        tick();
        check("lrst_cnt", 32'(cnt0), 32'h0);
        check("lrst_ovf", 32'(ovf0), 32'h0);
        r0 = 4'h0; s0 = 4'b0001; sv0 = 4'd13;
        tick();
        check("set13_cnt", 32'(cnt0), 32'h000D);
        check("set13_tc",  32'(tc0),  32'h0);
        check("set13_eq",  32'(eq0),  32'h0);
        s0 = 4'h0; e0 = 4'b0001; st0 = 3'd4;
        tick();
        check("wrap4_cnt", 32'(cnt0), 32'h0001);
        check("wrap4_tc",  32'(tc0),  32'h1);
        check("wrap4_ovf", 32'(ovf0), 32'(ov(4'b0001)));
        e0 = 4'h0;
        tick();
        check("idle_tc",  32'(tc0),  32'h0);
        check("idle_cnt", 32'(cnt0), 32'h0001);

        // Priority: lane2 rst+set+en, lane1 set+en
        r0 = 4'b0100; s0 = 4'b0110; e0 = 4'b0110; sv0 = 4'd7; st0 = 3'd1;
        tick();
        check("prio_cnt", 32'(cnt0), 32'h0071);
        check("prio_eq",  32'(eq0),  32'h0);
        check("prio_tc",  32'(tc0),  32'h0);
        check("prio_ovf", 32'(ovf0), 32'(ov(4'b0001)));

        // Continuous step 4 on all lanes, then Hard_RST mid-count
        r0 = 4'h0; s0 = 4'h0; e0 = 4'hF; st0 = 3'd4;
        tick();
        tick();
        check("run_t2_tc", 32'(tc0), 32'b0010);
        tick();
        tick();
        check("run_t4_cnt", 32'(cnt0), 32'h0071);
        check("run_t4_tc",  32'(tc0),  32'b1101);
        check("run_t4_ovf", 32'(ovf0), 32'(ov(4'hF)));
        hrst = 1'b1;
        tick();
        check("hrst_cnt", 32'(cnt0), 32'h0);
        check("hrst_ovf", 32'(ovf0), 32'h0);
        check("hrst_eq",  32'(eq0),  32'h1);
        check("hrst_tc",  32'(tc0),  32'h0);
        hrst = 1'b0; st0 = 3'd1;
        tick();
        check("resume_cnt", 32'(cnt0), 32'h1111);
        check("resume_eq",  32'(eq0),  32'h1);
        e0 = 4'h0;

        // Saturating bank, MAX=10
        s1 = 2'b11; sv1 = 4'd8;
        tick();
        check("sat_set_cnt", 32'(cnt1), 32'h88);
        check("sat_set_eq",  32'(eq1),  32'h1);
        s1 = 2'b00; e1 = 2'b01; st1 = 3'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_cnt", 32'(cnt1), 32'h8A);
            check("sat_tc",  32'(tc1),  32'h1);
            check("sat_ovf", 32'(ovf1), 32'(ov(4'b0001)));
            check("sat_eq",  32'(eq1),  32'h0);
        end
        e1 = 2'b10; st1 = 3'd2;
        tick();
        check("sat_hit_cnt", 32'(cnt1), 32'hAA);
        check("sat_hit_tc",  32'(tc1),  32'h2);
        check("sat_hit_ovf", 32'(ovf1), 32'(ov(4'b0001)));
        check("sat_hit_eq",  32'(eq1),  32'h1);
        e1 = 2'b00;

        // Wrapping bank, MAX=9: set clamp, step 0, then wrap
        s2 = 2'b11; sv2 = 4'd14;
        tick();
        check("clamp_cnt", 32'(cnt2), 32'h99);
        check("clamp_tc",  32'(tc2),  32'h0);
        s2 = 2'b00; e2 = 2'b11; st2 = 3'd0;
        tick();
        check("step0_cnt", 32'(cnt2), 32'h99);
        check("step0_tc",  32'(tc2),  32'h0);
        check("step0_ovf", 32'(ovf2), 32'h0);
        st2 = 3'd1;
        tick();
        check("wrap9_cnt", 32'(cnt2), 32'h00);
        check("wrap9_tc",  32'(tc2),  32'h3);
        check("wrap9_ovf", 32'(ovf2), 32'(ov(4'b0011)));
        e2 = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
